// File: rtl/vga_if_pkg.sv
// Shared encodings for the VGA register shadow: FSM states, CTRL bit layout
// and the CTRL register position relative to the staging window.
package vga_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COPY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // CTRL read layout
   localparam int CTRL_SEM    = 0;
   localparam int CTRL_BUSY   = 1;
   localparam int CTRL_MISSED = 2;
   localparam int CTRL_ERR    = 3;

   // CTRL write layout
   localparam int WR_SET_SEM  = 0;
   localparam int WR_CLR_ERR  = 1;

   // CTRL sits directly after the last staging register
   function automatic int ctrl_offset(input int num_regs);
      return num_regs;
   endfunction

endpackage

// File: rtl/vga_io_decode.sv
// CPU I/O address decode for the shadow window: staging select (one-hot)
// plus CTRL read/write strobes; purely combinational.
module vga_io_decode
   import vga_if_pkg::*;
#(
   parameter int          ADDRESS_WIDTH = 16,
   parameter int          NUM_REGS      = 4,
   parameter int unsigned BASE_ADDR     = 16'h0040
) (
   input  logic [ADDRESS_WIDTH-1:0] i_addr,
   input  logic                     i_wr,
   input  logic                     i_rd,
   output logic                     o_stg_wr,
   output logic                     o_stg_rd,
   output logic [NUM_REGS-1:0]      o_stg_sel,
   output logic                     o_ctrl_wr,
   output logic                     o_ctrl_rd
);

   localparam logic [ADDRESS_WIDTH-1:0] L_BASE = ADDRESS_WIDTH'(BASE_ADDR);
   localparam logic [ADDRESS_WIDTH-1:0] L_CTRL = ADDRESS_WIDTH'(ctrl_offset(NUM_REGS));

   logic [ADDRESS_WIDTH-1:0] w_off;
   logic                     w_hit_stg;
   logic                     w_hit_ctrl;

   // Subtracting the base wraps addresses below the window to large offsets
   assign w_off = i_addr - L_BASE;

   always_comb begin
      o_stg_sel = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         o_stg_sel[k] = (w_off == ADDRESS_WIDTH'(k));
      end
   end

   assign w_hit_stg  = |o_stg_sel;
   assign w_hit_ctrl = (w_off == L_CTRL);

   assign o_stg_wr  = i_wr & w_hit_stg;
   assign o_stg_rd  = i_rd & w_hit_stg;
   assign o_ctrl_wr = i_wr & w_hit_ctrl;
   assign o_ctrl_rd = i_rd & w_hit_ctrl;

endmodule

// File: rtl/vga_reg_shadow.sv
// Double-buffered video registers: CPU stages values, then on a qualified
// frame start they are streamed out one per cycle with a one-hot load strobe.
module vga_reg_shadow
   import vga_if_pkg::*;
#(
   parameter int          DATA_WIDTH    = 16,
   parameter int          ADDRESS_WIDTH = 16,
   parameter int          NUM_REGS      = 4,
   parameter int unsigned BASE_ADDR     = 16'h0040,
   parameter int          COMMIT_MODE   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDRESS_WIDTH-1:0]    cpu_addr,
   input  logic [DATA_WIDTH-1:0]       cpu_din,
   input  logic                        io_wr,
   input  logic                        io_rd,
   input  logic                        screenbegin,
   output logic [DATA_WIDTH-1:0]       cpu_dout,
   output logic [DATA_WIDTH-1:0]       reg_data,
   output logic [$clog2(NUM_REGS)-1:0] reg_idx,
   output logic [NUM_REGS-1:0]         en,
   output logic                        sem,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int              IW     = $clog2(NUM_REGS);
   localparam logic [IW-1:0]   L_LAST = IW'(NUM_REGS - 1);

   logic                  w_stg_wr, w_stg_rd, w_ctrl_wr, w_ctrl_rd;
   logic [NUM_REGS-1:0]   w_stg_sel;

   state_t                r_state, w_state_nxt;
   logic [IW-1:0]         r_idx, w_idx_nxt, w_idx_inc;
   logic [NUM_REGS-1:0]   r_en, w_en_nxt;
   logic                  r_done, w_done_nxt;
   logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic [DATA_WIDTH-1:0] r_stg [NUM_REGS];
   logic                  r_sem, r_err, r_missed;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] w_stg_rdat, w_ctrl_rdat;
   logic                  w_busy, w_start;

   vga_io_decode #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_REGS      (NUM_REGS),
      .BASE_ADDR     (BASE_ADDR)
   ) u_decode (
      .i_addr    (cpu_addr),
      .i_wr      (io_wr),
      .i_rd      (io_rd),
      .o_stg_wr  (w_stg_wr),
      .o_stg_rd  (w_stg_rd),
      .o_stg_sel (w_stg_sel),
      .o_ctrl_wr (w_ctrl_wr),
      .o_ctrl_rd (w_ctrl_rd)
   );

   assign w_busy    = (r_state != ST_IDLE);
   assign w_start   = screenbegin && (r_state == ST_IDLE) && ((COMMIT_MODE == 0) || r_sem);
   assign w_idx_inc = r_idx + IW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_en_nxt    = '0;
      w_done_nxt  = 1'b0;
      w_data_nxt  = r_data;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_COPY;
               w_idx_nxt   = '0;
               w_en_nxt    = NUM_REGS'(1);
               w_data_nxt  = r_stg[0];
            end
         end
         ST_COPY: begin
            if (r_idx == L_LAST) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_idx_nxt  = w_idx_inc;
               w_en_nxt   = NUM_REGS'(1) << w_idx_inc;
               w_data_nxt = r_stg[w_idx_inc];
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_en    <= '0;
         r_done  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_en    <= w_en_nxt;
         r_done  <= w_done_nxt;
         r_data  <= w_data_nxt;
      end
   end

   always_comb begin
      w_stg_rdat = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_stg_sel[k]) w_stg_rdat = w_stg_rdat | r_stg[k];
      end
      w_ctrl_rdat              = '0;
      w_ctrl_rdat[CTRL_SEM]    = r_sem;
      w_ctrl_rdat[CTRL_BUSY]   = w_busy;
      w_ctrl_rdat[CTRL_MISSED] = r_missed;
      w_ctrl_rdat[CTRL_ERR]    = r_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sem    <= 1'b0;
         r_err    <= 1'b0;
         r_missed <= 1'b0;
         r_dout   <= '0;
         for (int k = 0; k < NUM_REGS; k++) r_stg[k] <= '0;
      end else begin
         // A CPU set in the DONE cycle must survive the end-of-frame clear
         if (w_ctrl_wr && cpu_din[WR_SET_SEM]) r_sem <= 1'b1;
         else if (r_state == ST_DONE)          r_sem <= 1'b0;

         if (w_stg_wr && (r_sem || w_busy))     r_err <= 1'b1;
         else if (w_ctrl_wr && cpu_din[WR_CLR_ERR]) r_err <= 1'b0;

         if (screenbegin && w_busy) r_missed <= 1'b1;
         else if (w_ctrl_rd)        r_missed <= 1'b0;

         if (w_stg_wr && !r_sem && !w_busy) begin
            for (int k = 0; k < NUM_REGS; k++) begin
               if (w_stg_sel[k]) r_stg[k] <= cpu_din;
            end
         end

         if (w_ctrl_rd)     r_dout <= w_ctrl_rdat;
         else if (w_stg_rd) r_dout <= w_stg_rdat;
      end
   end

   assign cpu_dout   = r_dout;
   assign reg_data   = r_data;
   assign reg_idx    = r_idx;
   assign en         = r_en;
   assign sem        = r_sem;
   assign busy       = w_busy;
   assign frame_done = r_done;

endmodule

// File: tb/tb_vga_reg_shadow.sv
// Scoreboard bench for vga_reg_shadow: stimulus pushes expected copy beats,
// frame_done cycles and read data; a negedge monitor pops and compares.
module tb_vga_reg_shadow;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int NR = 4;
   localparam logic [AW-1:0] CTRL_A = 16'h0044;

   typedef struct {
      int          cyc;
      logic [3:0]  en;
      logic [1:0]  idx;
      logic [15:0] data;
   } beat_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } rd_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_din = '0;
   logic          io_wr = 1'b0, io_rd = 1'b0, sb = 1'b0, sb0 = 1'b0;

   logic [DW-1:0] cpu_dout, reg_data, dout0, data0;
   logic [1:0]    reg_idx, idx0;
   logic [NR-1:0] en, en0;
   logic          sem, busy, frame_done, sem0, busy0, done0;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic rd_pend = 1'b0;

   beat_t cq[$], cq0[$];
   rd_t   rq[$];
   int    dq[$], dq0[$];
   beat_t mb;
   rd_t   mr;
   int    md;

   vga_reg_shadow #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR),
                    .BASE_ADDR(16'h0040), .COMMIT_MODE(1)) dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .io_wr(io_wr), .io_rd(io_rd), .screenbegin(sb), .cpu_dout(cpu_dout),
      .reg_data(reg_data), .reg_idx(reg_idx), .en(en), .sem(sem),
      .busy(busy), .frame_done(frame_done));

   vga_reg_shadow #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR),
                    .BASE_ADDR(16'h0040), .COMMIT_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .cpu_addr(16'h0000), .cpu_din(16'h0000),
      .io_wr(1'b0), .io_rd(1'b0), .screenbegin(sb0), .cpu_dout(dout0),
      .reg_data(data0), .reg_idx(idx0), .en(en0), .sem(sem0),
      .busy(busy0), .frame_done(done0));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pend <= io_rd;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic io_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_addr = a; cpu_din = d; io_wr = 1'b1;
      tick();
      io_wr = 1'b0;
   endtask

   task automatic io_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      cpu_addr = a; io_rd = 1'b1;
      rq.push_back('{cyc + 1, exp});
      tick();
      io_rd = 1'b0;
   endtask

   task automatic pulse(input bit on0);
      if (on0) sb0 = 1'b1; else sb = 1'b1;
      tick();
      sb = 1'b0; sb0 = 1'b0;
   endtask

   task automatic push_copy(input int t, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
      logic [15:0] dv [4];
      dv = '{d0, d1, d2, d3};
      for (int k = 0; k < 4; k++) cq.push_back('{t + 1 + k, 4'(1 << k), 2'(k), dv[k]});
      dq.push_back(t + 5);
   endtask

   // Monitor: every DUT-presented output is matched against the queues
   always @(negedge clk) begin
      if (en != '0) begin
         n_chk++;
         if (cq.size() == 0) $display("FAIL unexpected_en: en=%b at cycle %0d, expected no copy", en, cyc);
         else begin
            mb = cq.pop_front();
            if (mb.cyc == cyc && mb.en == en && mb.idx == reg_idx && mb.data == reg_data) n_pass++;
            else $display("FAIL copy_beat: got cyc=%0d en=%b idx=%0d data=%h expected cyc=%0d en=%b idx=%0d data=%h",
                          cyc, en, reg_idx, reg_data, mb.cyc, mb.en, mb.idx, mb.data);
         end
      end
      if (frame_done) begin
         n_chk++;
         if (dq.size() == 0) $display("FAIL unexpected_done: at cycle %0d, expected none", cyc);
         else begin
            md = dq.pop_front();
            if (md == cyc) n_pass++;
            else $display("FAIL frame_done: got cycle %0d expected cycle %0d", cyc, md);
         end
      end
      if (rd_pend) begin
         n_chk++;
         if (rq.size() == 0) $display("FAIL unexpected_read: cycle %0d", cyc);
         else begin
            mr = rq.pop_front();
            if (mr.cyc == cyc && mr.data == cpu_dout) n_pass++;
            else $display("FAIL read_data: got %h at cycle %0d expected %h at cycle %0d",
                          cpu_dout, cyc, mr.data, mr.cyc);
         end
      end
      if (en0 != '0) begin
         n_chk++;
         if (cq0.size() == 0) $display("FAIL unexpected_en0: en=%b at cycle %0d, expected no copy", en0, cyc);
         else begin
            mb = cq0.pop_front();
            if (mb.cyc == cyc && mb.en == en0 && mb.idx == idx0 && mb.data == data0) n_pass++;
            else $display("FAIL copy_beat0: got cyc=%0d en=%b idx=%0d data=%h expected cyc=%0d en=%b idx=%0d data=%h",
                          cyc, en0, idx0, data0, mb.cyc, mb.en, mb.idx, mb.data);
         end
      end
      if (done0) begin
         n_chk++;
         if (dq0.size() == 0) $display("FAIL unexpected_done0: at cycle %0d, expected none", cyc);
         else begin
            md = dq0.pop_front();
            if (md == cyc) n_pass++;
            else $display("FAIL frame_done0: got cycle %0d expected cycle %0d", cyc, md);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int t;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_en", 32'(en), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_sem_busy", 32'({sem, busy}), 0);
      check("rst_dout", 32'(cpu_dout), 0);
      check("rst_reg_data_idx", 32'({reg_data, reg_idx}), 0);
      tick();
      rst = 1'b1;
      tick();

      // Basic commit with semaphore
      io_write(16'h0040, 16'h1111);
      io_write(16'h0041, 16'h2222);
      io_write(16'h0042, 16'h3333);
      io_write(16'h0043, 16'h4444);
      io_read(16'h0041, 16'h2222);
      io_write(16'h0050, 16'hDEAD);
      io_read(16'h0043, 16'h4444);
      io_write(CTRL_A, 16'h0001);
      io_read(CTRL_A, 16'h0001);
      t = cyc;
      push_copy(t, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      pulse(1'b0);
      tick();
      io_read(CTRL_A, 16'h0003);
      tick(3);
      @(negedge clk);
      check("sem_cleared_t6", 32'(sem), 0);
      check("busy_idle_t6", 32'(busy), 0);
      tick();
      io_read(CTRL_A, 16'h0000);

      // No semaphore: mode 1 ignores frame start, mode 0 copies anyway
      pulse(1'b0);
      @(negedge clk);
      check("no_commit_busy", 32'(busy), 0);
      tick();
      t = cyc;
      for (int k = 0; k < 4; k++) cq0.push_back('{t + 1 + k, 4'(1 << k), 2'(k), 16'h0000});
      dq0.push_back(t + 5);
      pulse(1'b1);
      tick(6);

      // Writes while sem is set are dropped and flag err
      io_write(CTRL_A, 16'h0001);
      io_write(16'h0041, 16'hBEEF);
      io_read(16'h0041, 16'h2222);
      io_read(CTRL_A, 16'h0009);
      io_write(CTRL_A, 16'h0002);
      io_read(CTRL_A, 16'h0001);

      // Frame start while busy is missed; missed clears on read
      t = cyc;
      push_copy(t, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      pulse(1'b0);
      tick();
      pulse(1'b0);
      tick(3);
      io_read(CTRL_A, 16'h0004);
      io_read(CTRL_A, 16'h0000);

      // Sem set in the DONE cycle wins over the clear
      io_write(CTRL_A, 16'h0001);
      t = cyc;
      push_copy(t, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      pulse(1'b0);
      tick(4);
      io_write(CTRL_A, 16'h0001);
      @(negedge clk);
      check("sem_set_wins", 32'(sem), 1);
      tick();
      t = cyc;
      push_copy(t, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      pulse(1'b0);
      tick(6);
      @(negedge clk);
      check("sem_after_second", 32'(sem), 0);
      tick();

      // Reset in the middle of a copy
      io_read(16'h0040, 16'h1111);
      io_write(CTRL_A, 16'h0001);
      t = cyc;
      cq.push_back('{t + 1, 4'b0001, 2'd0, 16'h1111});
      pulse(1'b0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_en", 32'(en), 0);
      check("mid_rst_data_idx", 32'({reg_data, reg_idx}), 0);
      check("mid_rst_sem_busy_done", 32'({sem, busy, frame_done}), 0);
      check("mid_rst_dout", 32'(cpu_dout), 0);
      tick(2);
      rst = 1'b1;
      tick(8);
      io_read(CTRL_A, 16'h0000);
      io_read(16'h0041, 16'h0000);
      io_write(16'h0040, 16'hAAAA);
      io_write(CTRL_A, 16'h0001);
      t = cyc;
      push_copy(t, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000);
      pulse(1'b0);
      tick(7);

      check("copy_queue_drained", 32'(cq.size()), 0);
      check("done_queue_drained", 32'(dq.size()), 0);
      check("read_queue_drained", 32'(rq.size()), 0);
      check("copy0_drained", 32'(cq0.size() + dq0.size()), 0);
      check("mode0_idle", 32'({sem0, busy0, dout0}), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
